// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DMEM between a priority CPU port and a host req/ack port
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter logic [31:0] BASE = 32'h10010000,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [31:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [31:0] host_off;
  logic host_ok, gnt;
  // Range check, host grant (free cycle or wait exhausted) and DMEM mux
  always_comb begin
    host_off = host_addr - BASE;
    host_ok = host_off < (32'd4 << ADDR_W) && host_addr[1:0] == 2'b00;
    gnt = state == PEND && (!cpu_req || wait_cnt == CW'(MAX_WAIT));
    cpu_stall = gnt & cpu_req;
    host_ack = state == ACK;
    mem_wena = gnt ? lat_we : cpu_req & cpu_we;
    mem_addr = gnt ? lat_addr : ADDR_W'((cpu_addr - BASE) >> 2);
    mem_wdata = gnt ? lat_wdata : cpu_wdata;
    cpu_rdata = mem_rdata;
  end
  // Host transaction FSM: latch command, wait for a free or forced slot, then ack
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      host_err <= 1'b0;
      host_rdata <= '0;
    end else
      case (state)
        IDLE:
          if (host_req && host_ok) begin
            lat_we <= host_we;
            lat_addr <= ADDR_W'(host_off >> 2);
            lat_wdata <= host_wdata;
            wait_cnt <= '0;
            state <= PEND;
          end else if (host_req) begin
            host_err <= 1'b1;
            host_rdata <= '0;
            state <= ACK;
          end
        PEND:
          if (gnt) begin
            host_rdata <= mem_rdata;
            host_err <= 1'b0;
            state <= ACK;
          end else
            wait_cnt <= wait_cnt + CW'(1);
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized host/CPU traffic checked against a word-memory and latency model
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'h10010000;
  localparam int MW = 4;
  logic clk_in = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic host_req, host_we, host_ack, host_err;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic mem_wena;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] dmem [0:2047];
  logic [31:0] refm [0:2047];
  bit known [0:2047];
  int n_cmp = 0;
  int n_bad = 0;
  int s;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(11), .BASE(BASE), .MAX_WAIT(MW)) dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk_in) if (mem_wena) dmem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_cpu(input int mode, input int t);
    cpu_req = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom) : 1'(t % 2);
    cpu_we = 1'($urandom);
    cpu_addr = BASE + ($urandom_range(0, 15) << 2);
    cpu_wdata = $urandom;
  endtask

  task automatic cpu_cycle();
    int ci;
    ci = int'((cpu_addr - BASE) >> 2);
    chk("cpu_mem_addr", 32'(mem_addr), ci);
    chk("cpu_mem_wena", 32'(mem_wena), 32'(cpu_req & cpu_we));
    if (cpu_req && cpu_we) chk("cpu_mem_wdata", mem_wdata, cpu_wdata);
    if (known[ci]) chk("cpu_rdata", cpu_rdata, refm[ci]);
    if (cpu_req && cpu_we) begin
      refm[ci] = cpu_wdata;
      known[ci] = 1'b1;
    end
  endtask

  task automatic host_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input int mode, output int stalls);
    logic [31:0] off, exp_rd;
    bit valid, g, rd_known;
    int idx, gt, at;
    off = a - BASE;
    valid = off < 32'h2000 && a[1:0] == 2'b00;
    idx = int'(off[12:2]);
    gt = -1;
    at = valid ? -1 : 1;
    exp_rd = '0;
    rd_known = 1'b0;
    stalls = 0;
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    for (int t = 0; t <= MW + 2; t++) begin
      drive_cpu(mode, t);
      if (t > 0) begin
        host_we = ~we;
        host_addr = $urandom;
        host_wdata = $urandom;
      end
      g = valid && gt < 0 && t >= 1 && (!cpu_req || t - 1 == MW);
      if (g) begin
        gt = t;
        at = t + 1;
      end
      #1;
      chk("cpu_stall", 32'(cpu_stall), 32'(g & cpu_req));
      stalls += int'(cpu_stall);
      chk("host_ack", 32'(host_ack), 32'(t == at));
      if (g) begin
        chk("host_mem_wena", 32'(mem_wena), 32'(we));
        chk("host_mem_addr", 32'(mem_addr), idx);
        if (we) chk("host_mem_wdata", mem_wdata, d);
        rd_known = known[idx];
        exp_rd = refm[idx];
        if (we) begin
          refm[idx] = d;
          known[idx] = 1'b1;
        end
      end else
        cpu_cycle();
      if (t == at) begin
        chk("host_err", 32'(host_err), 32'(!valid));
        if (!valid) chk("host_rdata_err", host_rdata, 32'h0);
        else if (rd_known) chk("host_rdata", host_rdata, exp_rd);
      end
      cyc();
      if (t == at) break;
    end
    host_req = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("ack_once", 32'(host_ack), 32'h0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = BASE; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = BASE; host_wdata = 0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_ack", 32'(host_ack), 0);
    chk("rst_err", 32'(host_err), 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    reset = 1'b0;
    cyc();
    host_txn(1'b1, 32'h10010008, 32'hDEADBEEF, 0, s);
    chk("idle_wr_stalls", s, 0);
    host_txn(1'b0, 32'h10010008, 32'h0, 0, s);
    chk("idle_rd_stalls", s, 0);
    for (int i = 0; i < 16; i++) host_txn(1'b1, BASE + 32'(i * 4), $urandom, 0, s);
    host_txn(1'b0, 32'h10010008, 32'h0, 1, s);
    chk("forced_stalls", s, 1);
    host_txn(1'b1, BASE + 32'h10, $urandom, 1, s);
    chk("forced_wr_stalls", s, 1);
    host_txn(1'b1, 32'h1000FFFC, $urandom, 0, s);
    host_txn(1'b0, 32'h10010002, $urandom, 0, s);
    host_txn(1'b0, 32'h10012000, $urandom, 1, s);
    chk("err_stalls", s, 0);
    host_txn(1'b1, 32'h10011FFC, 32'h5A5A1234, 0, s);
    host_txn(1'b0, 32'h10011FFC, 32'h0, 0, s);
    host_txn(1'b0, BASE + 32'h4, 32'h0, 3, s);
    chk("alt_stalls", s, 0);
    for (int i = 0; i < 30; i++)
      host_txn(1'($urandom), ($urandom_range(0, 9) == 0) ? BASE + 32'h1 : BASE + ($urandom_range(0, 15) << 2),
               $urandom, 2, s);
    for (int i = 0; i < 16; i++) host_txn(1'b0, BASE + 32'(i * 4), 32'h0, 0, s);
    host_req = 1'b1; host_we = 1'b1; host_addr = BASE + 32'h14; host_wdata = 32'hA5A5A5A5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE + 32'h40;
    cyc();
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(cpu_stall), 0);
    chk("mid_rst_ack", 32'(host_ack), 0);
    chk("mid_rst_err", 32'(host_err), 0);
    chk("mid_rst_rdata", host_rdata, 0);
    chk("mid_rst_wena", 32'(mem_wena), 0);
    host_req = 1'b0;
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_ack", 32'(host_ack), 0);
      chk("rst_no_wena", 32'(mem_wena), 0);
    end
    reset = 1'b0;
    cyc();
    chk("post_rst_ack", 32'(host_ack), 0);
    host_txn(1'b0, BASE + 32'h14, 32'h0, 0, s);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (DMEM) between the single-cycle CPU data port and a host debug/loader port that uses a req/ack handshake.
- CPU accesses pass through combinationally and have priority. Host accesses use free cycles.
- A host request that waits MAX_WAIT cycles forces one CPU stall cycle and is served in that cycle.
- Byte addresses from both ports are translated to DMEM word indices.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 11, DMEM word-index width (depth 2^ADDR_W words).
- BASE, 32'h10010000, byte address of DMEM word 0.
- MAX_WAIT, 4, maximum number of cycles a pending host request waits before it forces a stall (must be ≥1).

Ports:
- clk_in  in  1  CPU clock (same clock as DMEM).
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU performs a DMEM access this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to the CPU (combinational, equal to mem_rdata).
- cpu_stall  out  1  CPU must not commit state this cycle.
- host_req  in  1  host request; held high with host_we/host_addr/host_wdata stable until host_ack.
- host_we  in  1  host write enable.
- host_addr  in  32  host byte address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  registered host read data, valid with host_ack and held until the next ack.
- host_err  out  1  registered error flag: address out of range or misaligned; valid with host_ack.
- mem_wena  out  1  DMEM write enable.
- mem_addr  out  ADDR_W  DMEM word index.
- mem_wdata  out  DATA_W  DMEM write data.
- mem_rdata  in  DATA_W  DMEM asynchronous read data.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, wait_cnt=0.
  - host_ack=0, host_err=0, host_rdata=0, cpu_stall=0.
  - Latched host command cleared.
  - Reset mid-transaction abandons the transaction: no write occurs and no ack is issued.
- Address translation: index = ((addr − BASE) >> 2)[ADDR_W-1:0]. CPU addresses are not range-checked.
- Host range check, evaluated in IDLE: BASE ≤ host_addr < BASE + 4·2^ADDR_W and host_addr[1:0]==0.
- FSM states:
  - IDLE:
    - host_req=1 and address valid → latch we/addr/wdata, wait_cnt←0, go to PEND.
    - host_req=1 and address invalid → host_err←1, host_rdata←0, go to ACK. DMEM is never touched.
  - PEND:
    - Grant condition: cpu_req=0, or wait_cnt==MAX_WAIT.
    - Granted: DMEM is driven from the latched host command. mem_wena=latched we. host_rdata←mem_rdata at the clock edge (also captured on writes). host_err←0. Go to ACK.
    - Granted while cpu_req=1: cpu_stall=1 for this cycle only.
    - Not granted: wait_cnt++.
  - ACK: host_ack=1 for exactly one cycle, then go to IDLE. host_req is ignored in ACK, so the host must drop or re-present its request after the ack.
- DMEM mux (combinational):
  - Host-granted cycle → DMEM driven from the latched host command.
  - Otherwise → DMEM driven from the CPU port. mem_wena = cpu_req & cpu_we.
  - In a stall cycle the CPU write is suppressed.
- cpu_stall is asserted only in a forced grant. It is never asserted when cpu_req=0.
- Latency:
  - Idle CPU: host_req first seen at edge k → access in cycle k+1 → host_ack in cycle k+2.
  - Busy CPU: worst-case host_ack at k+MAX_WAIT+2.
- Starvation bound: at most one stall per host transaction.
- Simultaneous CPU and host access in a non-forced cycle: the CPU wins, and the host keeps waiting.
- Host inputs that change while in PEND are ignored, because the command is already latched.

Test Plan:
- Idle CPU, host write 0xDEADBEEF to 0x10010008 → mem_wena=1 with mem_addr=2 in the PEND cycle; host_ack 2 cycles after req; host_err=0; cpu_stall never asserted.
- Host read of 0x10010008 after that write → host_rdata=0xDEADBEEF at ack; DMEM contents unchanged.
- cpu_req held high continuously, host read pending → exactly one cpu_stall cycle, MAX_WAIT=4 cycles after entering PEND; host_ack on the following cycle; CPU write in the stall cycle does not reach DMEM.
- Host request to 0x1000FFFC and to 0x10010002 → host_ack with host_err=1, host_rdata=0; mem_wena stays 0.
- CPU idle every other cycle with host request pending → grant in the first cpu_req=0 cycle; no stall asserted.
- Assert reset while in PEND with a host write pending → no DMEM write, no ack; all outputs return to reset values immediately, without waiting for a clock edge.
